// File: rtl/ram_escritura.sv
// rtl/ram_escritura.sv - 4K x 8 writable memory with single-write and block-fill controller
module ram_escritura #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cargar_dir,
    input  logic [ADDR_W-1:0] dir_carga,
    input  logic [DATA_W-1:0] dato,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              fill_start,
    input  logic [ADDR_W:0]   fill_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] puntero,
    output logic [ADDR_W:0]   escritos,
    input  logic [ADDR_W-1:0] dir_lectura,
    output logic [DATA_W-1:0] salida
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ESC_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_puntero;
    logic [ADDR_W:0]   r_escritos;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_we;
    logic              w_latch;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W-1:0] w_base;

    assign wr_ready = (r_state == IDLE) & ~fill_start;
    assign busy     = (r_state == FILL);
    assign done     = (r_state == DONE);
    assign puntero  = r_puntero;
    assign escritos = r_escritos;
    assign salida   = r_mem[dir_lectura];

    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        w_latch    = 1'b0;
        w_wdata    = dato;
        w_base     = cargar_dir ? dir_carga : r_puntero;
        w_waddr    = r_puntero;
        w_ptr_next = r_puntero;
        case (r_state)
            IDLE: begin
                w_ptr_next = w_base;
                if (fill_start) begin
                    w_latch = 1'b1;
                    w_next  = (fill_len == '0) ? DONE : FILL;
                end else if (wr_valid) begin
                    w_we       = 1'b1;
                    w_waddr    = w_base;
                    w_ptr_next = w_base + 1'b1;
                end
            end
            FILL: begin
                w_we       = 1'b1;
                w_wdata    = r_val;
                w_ptr_next = r_puntero + 1'b1;
                if (r_cnt == {{ADDR_W{1'b0}}, 1'b1}) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_puntero  <= '0;
            r_escritos <= '0;
            r_cnt      <= '0;
            r_val      <= '0;
        end else begin
            r_state   <= w_next;
            r_puntero <= w_ptr_next;
            if (w_latch) begin
                r_cnt <= fill_len;
                r_val <= dato;
            end else if (r_state == FILL) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_we && (r_escritos != ESC_MAX)) begin
                r_escritos <= r_escritos + 1'b1;
            end
        end
    end

    // Storage has no reset; gating on reset keeps an IDLE write request from landing while reset is held.
    always_ff @(posedge clk) begin
        if (w_we && reset) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_ram_escritura.sv
// tb/tb_ram_escritura.sv - self-checking bench for ram_escritura
module tb_ram_escritura;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cargar_dir = 1'b0;
    logic [AW-1:0] dir_carga = '0;
    logic [DW-1:0] dato = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          fill_start = 1'b0;
    logic [AW:0]   fill_len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] puntero;
    logic [AW:0]   escritos;
    logic [AW-1:0] dir_lectura = '0;
    logic [DW-1:0] salida;

    ram_escritura #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .cargar_dir(cargar_dir), .dir_carga(dir_carga),
        .dato(dato), .wr_valid(wr_valid), .wr_ready(wr_ready), .fill_start(fill_start),
        .fill_len(fill_len), .busy(busy), .done(done), .puntero(puntero),
        .escritos(escritos), .dir_lectura(dir_lectura), .salida(salida)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            m_ptr = 0;
    int            m_esc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_write(input int a, input logic [DW-1:0] d);
        m_mem[a % DEPTH]   = d;
        m_known[a % DEPTH] = 1'b1;
        m_esc = (m_esc + 1 > DEPTH) ? DEPTH : m_esc + 1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_puntero"}, 32'(puntero), m_ptr);
        check({tag, "_escritos"}, 32'(escritos), m_esc);
    endtask

    task automatic check_mem(input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            a = (lo + i) % DEPTH;
            if (m_known[a]) begin
                dir_lectura = a[AW-1:0];
                #1;
                check($sformatf("mem_%03h", a), 32'(salida), 32'(m_mem[a]));
            end
        end
    endtask

    task automatic load(input int a);
        cargar_dir = 1'b1;
        dir_carga  = a[AW-1:0];
        tick();
        cargar_dir = 1'b0;
        m_ptr = a;
        check("load_puntero", 32'(puntero), a);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        dato        = d;
        wr_valid    = 1'b1;
        dir_lectura = m_ptr[AW-1:0];
        #1;
        check("wr_ready_idle", 32'(wr_ready), 1);
        if (m_known[m_ptr]) check("rdw_old", 32'(salida), 32'(m_mem[m_ptr]));
        tick();
        wr_valid = 1'b0;
        check("rdw_new", 32'(salida), 32'(d));
        m_write(m_ptr, d);
        m_ptr = (m_ptr + 1) % DEPTH;
        check_regs("wr");
    endtask

    task automatic fill(input logic [DW-1:0] v, input int len, input bit with_wr);
        int cycles;
        dato       = v;
        fill_len   = len[AW:0];
        fill_start = 1'b1;
        wr_valid   = with_wr;
        #1;
        check("wr_ready_at_fill_start", 32'(wr_ready), 0);
        tick();
        fill_start = 1'b0;
        wr_valid   = 1'b0;
        dato       = ~v;
        fill_len   = AW'($urandom);
        cycles     = 0;
        while (busy === 1'b1 && cycles < DEPTH + 8) begin
            check("done_low_in_fill", 32'(done), 0);
            check("wr_ready_in_fill", 32'(wr_ready), 0);
            cycles++;
            tick();
        end
        check("fill_busy_cycles", cycles, len);
        check("done_pulse", 32'(done), 1);
        check("busy_low_in_done", 32'(busy), 0);
        check("wr_ready_in_done", 32'(wr_ready), 0);
        tick();
        check("done_one_cycle", 32'(done), 0);
        for (int i = 0; i < len; i++) m_write(m_ptr + i, v);
        m_ptr = (m_ptr + len) % DEPTH;
        check_regs("fill");
    endtask

    initial begin
        int a;
        logic [DW-1:0] d;

        #1;
        check("rst_puntero", 32'(puntero), 0);
        check("rst_escritos", 32'(escritos), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        tick();
        tick();
        reset = 1'b1;

        load('h010); wr(8'hA5); wr(8'h3C);
        check_mem('h010, 2);

        load('hFFE); wr(8'h11); wr(8'h22); wr(8'h33);
        check_mem('hFFE, 3);

        load('h0FF); wr(8'($urandom));
        load('h104); wr(8'($urandom));
        load('h100); fill(8'h5A, 4, 1'b0);
        check_mem('h0FF, 6);

        fill(8'hC3, 0, 1'b0);

        load('h300); fill(8'h77, 2, 1'b1);
        check_mem('h300, 3);

        a = int'($urandom_range(0, DEPTH - 1));
        d = 8'($urandom);
        cargar_dir = 1'b1; dir_carga = a[AW-1:0]; wr_valid = 1'b1; dato = d;
        tick();
        cargar_dir = 1'b0; wr_valid = 1'b0;
        m_write(a, d);
        m_ptr = (a + 1) % DEPTH;
        check_regs("load_and_write");
        check_mem(a, 1);

        for (int it = 0; it < 20; it++) begin
            a = int'($urandom_range(0, DEPTH - 1));
            load(a);
            if ($urandom_range(0, 1) == 0) begin
                int n;
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) wr(8'($urandom));
                check_mem(a, n);
            end else begin
                int n;
                n = int'($urandom_range(1, 20));
                fill(8'($urandom), n, 1'($urandom_range(0, 1)));
                check_mem(a, n + 1);
            end
        end

        a = int'($urandom_range(0, DEPTH - 1));
        load(a);
        fill(8'($urandom), DEPTH, 1'b0);
        check_mem(0, DEPTH);
        wr(8'h9D);

        load('h200); fill(8'h00, 8, 1'b0);
        load('h200);
        dato = 8'hEE; fill_len = 9'd8; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        check("abort_puntero", 32'(puntero), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_escritos", 32'(escritos), 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) m_write('h200 + i, 8'hEE);
        m_ptr = 0;
        m_esc = 0;
        check_regs("after_abort");
        check_mem('h200, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
